// File: rtl/systolic_mm_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_pkg : state encoding and timing helpers for the systolic MM control
// Rev 1.0
// ----------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_CLEAR  = 6'b000010,
    S_FEED   = 6'b000100,
    S_DRAIN  = 6'b001000,
    S_OUTPUT = 6'b010000,
    S_DONE   = 6'b100000
  } ctrl_state_t;

  // Read latency (1) + operand skew (n-1) + wavefront propagation (n-1).
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_mm_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_mm_ctrl_if : host command, PE/operand strobes and result-row handshake
// Rev 1.0
// ----------------------------------------------------------------------------
interface systolic_mm_ctrl_if
  import systolic_pkg::*;
#(
  parameter int N_SIZE = 5
) ();

  localparam int AW = $clog2(N_SIZE);

  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          pe_clear;
  logic          pe_en;
  logic          op_rd_en;
  logic [AW-1:0] op_rd_addr;
  logic          out_valid;
  logic [AW-1:0] out_row;
  logic          out_ready;

  modport master (
    output start, abort, out_ready,
    input  busy, done, pe_clear, pe_en, op_rd_en, op_rd_addr, out_valid, out_row
  );

  modport slave (
    input  start, abort, out_ready,
    output busy, done, pe_clear, pe_en, op_rd_en, op_rd_addr, out_valid, out_row
  );

endinterface
`default_nettype wire

// File: rtl/systolic_mm_ctrl_phase_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// phase_counter : up-counter with synchronous clear, enable and terminal flag
// Rev 1.0
// ----------------------------------------------------------------------------
module phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             at_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_last = (count == last);

endmodule
`default_nettype wire

// File: rtl/systolic_mm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_mm_ctrl : sequencer for one NxN output-stationary systolic multiply
// Rev 1.0
// ----------------------------------------------------------------------------
module systolic_mm_ctrl
  import systolic_pkg::*;
#(
  parameter  int N_SIZE = 5,
  localparam int AW     = $clog2(N_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  systolic_mm_ctrl_if.slave ctrl
);

  localparam int            PW         = $clog2(2 * N_SIZE);
  localparam logic [PW-1:0] FEED_LAST  = PW'(N_SIZE - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(drain_cycles(N_SIZE) - 1);
  localparam logic [AW-1:0] ROW_LAST   = AW'(N_SIZE - 1);

  ctrl_state_t   r_state;
  ctrl_state_t   w_next;
  logic          w_state_change;
  logic          w_in_phase;
  logic          w_xfer;
  logic [PW-1:0] w_phase_last;
  logic [PW-1:0] w_phase_cnt;
  logic          w_phase_at_last;
  logic [AW-1:0] w_row_cnt;
  logic          w_row_at_last;
  logic [AW-1:0] w_addr_next;

  assign w_state_change = (w_next != r_state);
  assign w_in_phase     = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign w_xfer         = (r_state == S_OUTPUT) && ctrl.out_ready;
  assign w_phase_last   = (r_state == S_FEED) ? FEED_LAST : DRAIN_LAST;

  // Both counters restart on every state change, so each phase begins at 0.
  phase_counter #(.WIDTH(PW)) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_state_change),
    .en      (w_in_phase),
    .last    (w_phase_last),
    .count   (w_phase_cnt),
    .at_last (w_phase_at_last)
  );

  phase_counter #(.WIDTH(AW)) u_row_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_state_change),
    .en      (w_xfer),
    .last    (ROW_LAST),
    .count   (w_row_cnt),
    .at_last (w_row_at_last)
  );

  assign ctrl.out_row = w_row_cnt;

  // Address presented next cycle: the phase count one step ahead.
  assign w_addr_next = (r_state == S_FEED) ? AW'(w_phase_cnt + PW'(1)) : '0;

  always_comb begin
    w_next = r_state;
    if (ctrl.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (ctrl.start)                w_next = S_CLEAR;
        S_CLEAR:                                 w_next = S_FEED;
        S_FEED:   if (w_phase_at_last)           w_next = S_DRAIN;
        S_DRAIN:  if (w_phase_at_last)           w_next = S_OUTPUT;
        S_OUTPUT: if (w_xfer && w_row_at_last)   w_next = S_DONE;
        S_DONE:                                  w_next = S_IDLE;
        default:                                 w_next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      ctrl.busy       <= 1'b0;
      ctrl.done       <= 1'b0;
      ctrl.pe_clear   <= 1'b0;
      ctrl.pe_en      <= 1'b0;
      ctrl.op_rd_en   <= 1'b0;
      ctrl.op_rd_addr <= '0;
      ctrl.out_valid  <= 1'b0;
    end else begin
      r_state         <= w_next;
      ctrl.busy       <= (w_next != S_IDLE);
      ctrl.done       <= (w_next == S_DONE);
      ctrl.pe_clear   <= (w_next == S_CLEAR);
      ctrl.pe_en      <= (w_next == S_FEED) || (w_next == S_DRAIN);
      ctrl.op_rd_en   <= (w_next == S_FEED);
      ctrl.op_rd_addr <= (w_next == S_FEED) ? w_addr_next : '0;
      ctrl.out_valid  <= (w_next == S_OUTPUT);
    end
  end

endmodule
`default_nettype wire

// File: doc/systolic_mm_ctrl.md
# systolic_mm_ctrl

Sequencing controller for one N×N output-stationary systolic matrix multiply. On `start` it clears the PE accumulators and streams N operand-buffer reads into the skew/feed logic. It then holds the array enabled until the wavefront drains and unloads the result one row per accepted handshake. It sits between the host command interface and the PE array, operand buffers and result row mux.

## Interface
- `N_SIZE`, 5: array dimension, minimum 2; rows, columns and inner dimension are all N_SIZE.
- `AW`, `$clog2(N_SIZE)`: width of row and address indices (derived; do not override).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel, valid in any state.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  single-cycle pulse after the last result row is accepted.
- `pe_clear`  out  1  synchronous accumulator clear to every PE.
- `pe_en`  out  1  PE MAC/shift enable.
- `op_rd_en`  out  1  operand buffer (A column / B row) read strobe.
- `op_rd_addr`  out  AW  operand index k.
- `out_valid`  out  1  result row presented.
- `out_row`  out  AW  index of the result row being presented.
- `out_ready`  in  1  downstream accepts the row.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE.
- IDLE: when `start`=1, go to CLEAR. All outputs are 0.
- CLEAR: lasts 1 cycle with `pe_clear`=1. Then go to FEED.
- FEED: lasts N_SIZE cycles. `op_rd_en`=1, `pe_en`=1, and `op_rd_addr` counts 0..N_SIZE-1. After the cycle with address N_SIZE-1, go to DRAIN.
- DRAIN: lasts 2·N_SIZE-1 cycles with `pe_en`=1. This covers 1 cycle of read latency, N-1 cycles of skew and N-1 cycles of propagation. Then go to OUTPUT with `out_row`=0.
- OUTPUT: `out_valid`=1 and `pe_en`=0. A transfer occurs when `out_valid`=1 and `out_ready`=1.
  - On a transfer with `out_row` < N_SIZE-1, `out_row` increments.
  - On a transfer with `out_row` = N_SIZE-1, go to DONE.
  - While `out_ready`=0, `out_row` holds.
- DONE: lasts 1 cycle with `done`=1. Then go to IDLE.
- A single phase counter is shared by FEED and DRAIN. It is 0 on entry to each state and is compared against that state's terminal count. Its width is `$clog2(2*N_SIZE)`.
- `abort`=1 in any non-IDLE state sends the next state to IDLE. No `done` pulse follows, and all outputs are 0 from the next cycle. `abort` has priority over every other transition.
- `start` while busy is ignored and is not queued. `start` together with `abort` in IDLE: `abort` wins and the state stays IDLE.

## Timing
- Reset values: state IDLE, all counters 0, all outputs 0.
- Reset mid-operation returns asynchronously to IDLE. A following `start` begins a full fresh sequence, including CLEAR.
- All outputs are registered and decoded from state and counters. There is no combinational path from inputs to outputs.
- Cycle numbering: `start` is sampled at edge 0.
  - Cycle 1: CLEAR.
  - Cycles 2..N+1: FEED.
  - Cycles N+2..3N: DRAIN.
  - From cycle 3N+1: OUTPUT.
- With `out_ready` held at 1, `done` is asserted in cycle 4N+1 and `busy` falls in cycle 4N+2.
- `out_row` and `out_valid` are stable while `out_valid`=1 and `out_ready`=0.
- The operand buffer has 1-cycle read latency. Data for `op_rd_addr`=k arrives in the cycle after the strobe and is covered by DRAIN.

## Structure
- Shared package `systolic_pkg` holds:
  - `ctrl_state_t`, an enum with one-hot encoding for IDLE..DONE.
  - The drain length function `drain_cycles(n)=2n-1`.
- One sub-module, `phase_counter`: a parameterised up-counter with synchronous clear, enable and a terminal-count flag. It is instantiated twice, once as the FEED/DRAIN phase counter and once as the OUTPUT row counter.
- The next-state and output decode live in the top module.

## Test plan
- N_SIZE=4, pulse `start`, `out_ready`=1:
  - `pe_clear` is high in cycle 1.
  - `op_rd_addr` is 0,1,2,3 in cycles 2–5.
  - `pe_en` is high in cycles 2–12.
  - `out_row` is 0..3 in cycles 13–16.
  - `done` is high in cycle 17; `busy` is 0 in cycle 18.
- N_SIZE=4, `out_ready` toggling 1,0,0,1,…:
  - Each row is held while `out_ready`=0.
  - Exactly 4 transfers occur.
  - `done` occurs 1 cycle after the 4th transfer.
- `abort` asserted in cycle 7 (DRAIN):
  - From cycle 8, `busy`=0 and all outputs are 0.
  - No `done` pulse occurs.
  - A following `start` repeats the first scenario's timing exactly.
- `start` pulsed repeatedly during FEED and OUTPUT: ignored, and the sequence timing is unchanged.
- `rst_n` dropped asynchronously mid-FEED:
  - Outputs go to 0 immediately.
  - After release, the state is IDLE.
- N_SIZE=2 boundary:
  - FEED lasts 2 cycles and DRAIN lasts 3 cycles.
  - `out_valid` first appears in cycle 7.
  - `done` is high in cycle 9.
